// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//   Shares one single-port, read-first block RAM (1-cycle read latency) between
//   two requesters: port 0 (instruction fetch) and port 1 (data / loader).
//   At most one access is granted per cycle. Read data is routed back to the
//   issuing port, and each port can hold its response under back-pressure.
//
//   Optional feature macro: BRAM_ARB_RR_EN
//     defined   -> round-robin arbitration on contention (port 0 first after
//                  reset; the pointer moves on every grant)
//     undefined -> fixed priority, port 1 wins; no pointer register exists
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   mX_req / mX_we            request valid / 1 = write
//   mX_addr / mX_wdata        word address / write data
//   mX_gnt                    request accepted this cycle (combinational)
//   mX_rvalid / mX_rdata      read response valid / data
//   mX_rready                 response consumed
//   mX_err                    one-cycle pulse after an out-of-range access
//   ram_en/we/addr/di         RAM drive
//   ram_dout                  RAM read data (valid the cycle after en)
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 16384
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m0_rready,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   input  logic              m1_rready,
   output logic              m1_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_di,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

   logic [1:0]        req, rdy, elig, gnt;
   logic [1:0]        vld_q;    // response valid, one bit per port
   logic [1:0]        fresh_q;  // response data is on ram_dout this cycle
   logic [1:0]        err_q;
   logic [DATA_W-1:0] hold_q [2];
   logic              win_we, win_oor;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   assign req = {m1_req, m0_req};
   assign rdy = {m1_rready, m0_rready};

   // A port whose response is still unconsumed may not issue; consuming it in
   // the same cycle frees the port, so back-to-back reads run at full rate.
   assign elig = req & ~(vld_q & ~rdy);

`ifdef BRAM_ARB_RR_EN
   logic prio_q;  // port that wins the next contention

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prio_q <= 1'b0;
      else if (|gnt) prio_q <= gnt[0];  // the other port gets priority
   end

   assign gnt[1] = elig[1] & (~elig[0] | prio_q);
   assign gnt[0] = elig[0] & (~elig[1] | ~prio_q);
`else
   assign gnt[1] = elig[1];
   assign gnt[0] = elig[0] & ~elig[1];
`endif

   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   // NOTE: every combinational output gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      if (gnt[1]) begin
         win_we    = m1_we;
         win_addr  = m1_addr;
         win_wdata = m1_wdata;
      end else if (gnt[0]) begin
         win_we    = m0_we;
         win_addr  = m0_addr;
         win_wdata = m0_wdata;
      end
   end

   assign win_oor  = win_addr >= LIMIT;
   assign ram_en   = (|gnt) & ~win_oor;
   assign ram_we   = ram_en & win_we;
   assign ram_addr = win_addr;
   assign ram_di   = win_wdata;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q   <= '0;
         fresh_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < 2; i++) hold_q[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            err_q[i] <= gnt[i] & win_oor;
            if (gnt[i] && !win_we) begin
               // Out-of-range reads answer with zero from the hold register.
               vld_q[i]   <= 1'b1;
               fresh_q[i] <= ~win_oor;
               if (win_oor) hold_q[i] <= '0;
            end else if (vld_q[i] && !rdy[i]) begin
               // Stalled: capture RAM data once, the RAM moves on afterwards.
               vld_q[i]   <= 1'b1;
               fresh_q[i] <= 1'b0;
               if (fresh_q[i]) hold_q[i] <= ram_dout;
            end else begin
               vld_q[i]   <= 1'b0;
               fresh_q[i] <= 1'b0;
            end
         end
      end
   end

   assign m0_rvalid = vld_q[0];
   assign m1_rvalid = vld_q[1];
   assign m0_rdata  = fresh_q[0] ? ram_dout : hold_q[0];
   assign m1_rdata  = fresh_q[1] ? ram_dout : hold_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port read-first block RAM (32-bit words, 1-cycle read latency, en/we/addr/di/dout) between two requesters.
- Port 0 is the instruction fetch; port 1 is data load/store or the program loader.
- Grants at most one access per cycle and routes read data back to the issuing port with a per-port response hold.
- Sits between the core/loader and the RAM.

Parameters:
- DATA_W, 32, word width.
- ADDR_W, 32, request address width (word address).
- DEPTH, 16384, RAM words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m0_req, m1_req  in  1  request valid
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  word address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  out  1  read response valid
- m0_rdata, m1_rdata  out  DATA_W  read data
- m0_rready, m1_rready  in  1  response consumed
- m0_err, m1_err  out  1  one-cycle pulse, out-of-range access
- ram_en  out  1  to RAM en
- ram_we  out  1  to RAM we
- ram_addr  out  ADDR_W  to RAM addr
- ram_di  out  DATA_W  to RAM di
- ram_dout  in  DATA_W  from RAM dout

Behaviour:
- Reset (async, active-high): all registered outputs 0; hold registers 0; pending flags clear; RR pointer = port 0.
  - In-flight reads are dropped; no rvalid appears after reset release for pre-reset requests.
- Eligibility: port x is eligible when mx_req = 1 and port x has no pending response (rvalid high and not yet consumed).
- Arbitration (combinational, cycle N):
  - At most one gnt per cycle.
  - Only one eligible port: that port is granted.
  - Both eligible: port 1 wins (fixed priority), unless RR mode is enabled (see Optional Feature).
- RAM drive in cycle N:
  - Winner in range: ram_en = 1, ram_we = winner we; ram_addr and ram_di from the winner.
  - No winner, or winner out of range: ram_en = 0 and ram_we = 0.
- Read latency:
  - Read granted in cycle N: mx_rvalid = 1 in N+1, and mx_rdata = ram_dout in N+1.
  - If mx_rready = 1 in N+1: response completes; the port is eligible again in N+1, so back-to-back reads sustain 1 per cycle.
  - If mx_rready = 0 in N+1: ram_dout is captured into the port's hold register at the end of N+1. rvalid stays 1 with the held value until the cycle rready = 1. The port gets no grants meanwhile.
- Writes: gnt only; no rvalid.
  - Read-first RAM semantics are not exposed; the old word is discarded.
- Same address, write by one port in N and read by the other in N+1: the read returns the new data.
- Out-of-range access (addr >= DEPTH):
  - Still granted.
  - RAM is not enabled; mx_err pulses in N+1.
  - A read also returns rvalid in N+1 with rdata = 0.
- Request held high after gnt is treated as a new request in the next cycle. Requesters drop req or change addr after gnt.
- rready while rvalid = 0 is ignored.

Optional Feature:
- Macro: BRAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. On contention, the port not granted most recently wins.
  - The pointer updates on every grant, including out-of-range grants.
  - With both ports continuously eligible, grants alternate 0,1,0,1…
- Undefined:
  - Fixed priority, port 1 wins. No pointer register is instantiated.

Test Plan:
- Single read: m0 read addr 5 (RAM[5] = 0xDEADBEEF), rready = 1 → m0_gnt in cycle N; m0_rvalid = 1 with rdata = 0xDEADBEEF in N+1 only.
- Contention: both ports read in the same cycle, addr 1 and 2 →
  - Fixed: m1 granted first, m0 next cycle.
  - BRAM_ARB_RR_EN: grants alternate starting with port 0 after reset.
- Back-pressure: m1 read addr 3 (0x12345678), m1_rready = 0 for 4 cycles while ram_dout changes →
  - m1_rvalid stays 1 with rdata = 0x12345678.
  - No m1_gnt during the stall.
  - m0 is still granted.
- Write then read: m1 writes 0xCAFEF00D to addr 10 in N; m0 reads addr 10 in N+1 → m0_rdata = 0xCAFEF00D in N+2; no rvalid for the write.
- Out-of-range: m0 reads addr 16384 → ram_en = 0; m0_err = 1 and m0_rvalid = 1 with rdata = 0 in N+1.
- Reset mid-read: rst asserted in N+1 of a granted read → all outputs 0 immediately; no rvalid after release.
